prompt_sequencer: RTL and testbench

Frame-synchronous screen sequencer for the VGA prompt overlays. It tracks game phase: switches-off check, start prompt, 3-2-1 countdown, play, and game over. It drives the `en` inputs of the prompt sprite controllers, including the switches-off prompt, and the countdown digit select. All overlay enables change only at end-of-frame, so a prompt never tears mid-frame. It sits between the user inputs/game core and the overlay controllers in the VGA top.

---
 rtl/vga_pkg.sv | 23 ++
 rtl/prompt_sequencer_timer.sv | 35 +++
 rtl/prompt_sequencer.sv | 165 ++++++++++++++++
 tb/tb_prompt_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA overlay definitions: sequencer state encoding, 800x525 timing
// constants and countdown digit values.
package vga_pkg;

    typedef enum logic [2:0] {
        CHECK_SW  = 3'd0,
        READY     = 3'd1,
        COUNTDOWN = 3'd2,
        PLAY      = 3'd3,
        OVER      = 3'd4
    } seq_state_t;

    localparam int H_LAST_DEF = 799;
    localparam int V_LAST_DEF = 524;

    localparam logic [1:0] DIGIT_FIRST = 2'd3;
    localparam logic [1:0] DIGIT_LAST  = 2'd1;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/prompt_sequencer_timer.sv
// Tick-qualified frame counter with wrap or saturate behaviour and a
// terminal-count flag (count == i_limit).
module frame_timer #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_tick,
    input  logic         i_clear,
    input  logic         i_saturate,
    input  logic [W-1:0] i_limit,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    assign o_tc = (r_count == i_limit);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_count <= '0;
        end else if (i_tick) begin
            if (i_clear) begin
                r_count <= '0;
            end else if (o_tc) begin
                if (!i_saturate) begin
                    r_count <= '0;
                end
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/prompt_sequencer.sv
// Frame-synchronous game-phase sequencer driving the VGA prompt overlay enables.
// Optional blinking of start/game-over prompts is built when PROMPT_BLINK_EN is defined.
module prompt_sequencer
    import vga_pkg::*;
#(
    parameter int H_LAST       = H_LAST_DEF,
    parameter int V_LAST       = V_LAST_DEF,
    parameter int BLINK_FRAMES = 30,
    parameter int COUNT_FRAMES = 60,
    parameter int OVER_HOLD    = 120
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [9:0] i_hCount,
    input  logic [9:0] i_vCount,
    input  logic       i_sw_any,
    input  logic       i_start_btn,
    input  logic       i_game_over,
    output logic       o_sw_off_en,
    output logic       o_start_en,
    output logic       o_countdown_en,
    output logic [1:0] o_digit,
    output logic       o_game_en,
    output logic       o_over_en,
    output logic       o_frame_tick
);

    localparam int FC_MAX = max2(COUNT_FRAMES - 1, OVER_HOLD);
    localparam int FCW    = (FC_MAX > 0) ? $clog2(FC_MAX + 1) : 1;
    localparam logic [FCW-1:0] L_COUNT_LAST = FCW'(COUNT_FRAMES - 1);
    localparam logic [FCW-1:0] L_OVER_HOLD  = FCW'(OVER_HOLD);

    if (BLINK_FRAMES < 1 || COUNT_FRAMES < 1 || OVER_HOLD < 0) begin : g_bad_params
        $error("prompt_sequencer: frame counts must be positive");
    end

    seq_state_t     r_state;
    seq_state_t     w_next;
    logic           w_tick;
    logic           w_start;
    logic           r_start_req;
    logic           r_frame_tick;
    logic [1:0]     r_digit;
    logic           w_fc_tc;
    logic           w_fc_clear;
    logic           w_fc_sat;
    logic [FCW-1:0] w_fc_limit;
    logic           w_next_phase;
    logic           w_sw_off_en, w_start_en, w_countdown_en, w_game_en, w_over_en;

    assign w_tick  = (i_hCount == 10'(H_LAST)) && (i_vCount == 10'(V_LAST));
    // A press landing on the tick cycle counts for that tick.
    assign w_start = r_start_req | i_start_btn;

    assign w_fc_sat   = (r_state == OVER);
    assign w_fc_clear = !((r_state == COUNTDOWN) || (r_state == OVER));
    assign w_fc_limit = w_fc_sat ? L_OVER_HOLD : L_COUNT_LAST;

    frame_timer #(.W(FCW)) u_frame_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_tick     (w_tick),
        .i_clear    (w_fc_clear),
        .i_saturate (w_fc_sat),
        .i_limit    (w_fc_limit),
        .o_tc       (w_fc_tc)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state      <= CHECK_SW;
            r_start_req  <= 1'b0;
            r_frame_tick <= 1'b0;
            r_digit      <= DIGIT_FIRST;
        end else begin
            r_frame_tick <= w_tick;
            if (w_tick) begin
                r_state     <= w_next;
                r_start_req <= 1'b0;
                if (r_state == READY && w_next == COUNTDOWN) begin
                    r_digit <= DIGIT_FIRST;
                end else if (r_state == COUNTDOWN && w_fc_tc && r_digit != DIGIT_LAST) begin
                    r_digit <= r_digit - 2'd1;
                end
            end else if (i_start_btn) begin
                r_start_req <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            CHECK_SW:  if (!i_sw_any) w_next = READY;
            READY: begin
                if (i_sw_any)     w_next = CHECK_SW;
                else if (w_start) w_next = COUNTDOWN;
            end
            COUNTDOWN: if (w_fc_tc && r_digit == DIGIT_LAST) w_next = PLAY;
            PLAY:      if (i_game_over) w_next = OVER;
            OVER:      if (w_fc_tc && w_start) w_next = CHECK_SW;
            default:   w_next = CHECK_SW;
        endcase
    end

`ifdef PROMPT_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic w_blink_restart;
    logic w_blink_tc;
    logic r_phase;

    // Each entry into a blinking screen starts in the visible half-period.
    assign w_blink_restart = (w_next != r_state) && (w_next == READY || w_next == OVER);
    assign w_next_phase    = w_blink_restart | (w_blink_tc ? ~r_phase : r_phase);

    frame_timer #(.W(BW)) u_blink_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_tick     (w_tick),
        .i_clear    (w_blink_restart),
        .i_saturate (1'b0),
        .i_limit    (BW'(BLINK_FRAMES - 1)),
        .o_tc       (w_blink_tc)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_phase <= 1'b1;
        end else if (w_tick) begin
            r_phase <= w_next_phase;
        end
    end
`else
    assign w_next_phase = 1'b1;
`endif

    always_comb begin
        w_sw_off_en    = (w_next == CHECK_SW);
        w_start_en     = (w_next == READY) & w_next_phase;
        w_countdown_en = (w_next == COUNTDOWN);
        w_game_en      = (w_next == PLAY);
        w_over_en      = (w_next == OVER) & w_next_phase;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_sw_off_en    <= 1'b0;
            o_start_en     <= 1'b0;
            o_countdown_en <= 1'b0;
            o_game_en      <= 1'b0;
            o_over_en      <= 1'b0;
        end else if (w_tick) begin
            o_sw_off_en    <= w_sw_off_en;
            o_start_en     <= w_start_en;
            o_countdown_en <= w_countdown_en;
            o_game_en      <= w_game_en;
            o_over_en      <= w_over_en;
        end
    end

    assign o_digit      = r_digit;
    assign o_frame_tick = r_frame_tick;

endmodule

// File: tb/tb_prompt_sequencer.sv
// Scoreboard bench for prompt_sequencer on a 10x5 (50 clk) frame; honours PROMPT_BLINK_EN.
module tb_prompt_sequencer;
    import vga_pkg::*;

    localparam int H_LAST       = 9;
    localparam int V_LAST       = 4;
    localparam int COUNT_FRAMES = 3;
    localparam int OVER_HOLD    = 4;
`ifdef PROMPT_BLINK_EN
    localparam int BLINK_FRAMES = 2;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] hCount = '0;
    logic [9:0] vCount = '0;
    logic       sw_any = 1'b1;
    logic       start_btn = 1'b0;
    logic       game_over = 1'b0;
    logic       sw_off_en, start_en, countdown_en, game_en, over_en, frame_tick;
    logic [1:0] digit;
    logic [6:0] outVec;

    always #5 clk = ~clk;

    prompt_sequencer #(
        .H_LAST       (H_LAST),
        .V_LAST       (V_LAST),
        .BLINK_FRAMES (2),
        .COUNT_FRAMES (COUNT_FRAMES),
        .OVER_HOLD    (OVER_HOLD)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_hCount       (hCount),
        .i_vCount       (vCount),
        .i_sw_any       (sw_any),
        .i_start_btn    (start_btn),
        .i_game_over    (game_over),
        .o_sw_off_en    (sw_off_en),
        .o_start_en     (start_en),
        .o_countdown_en (countdown_en),
        .o_digit        (digit),
        .o_game_en      (game_en),
        .o_over_en      (over_en),
        .o_frame_tick   (frame_tick)
    );

    assign outVec = {sw_off_en, start_en, countdown_en, digit, game_en, over_en};

    int         errors = 0;
    int         checks = 0;
    logic [6:0] sbQ[$];

    seq_state_t mState = CHECK_SW;
    int         mDigit = 3;
    int         mFc = 0;
    bit         mPhase = 1'b1;
    bit         mReq = 1'b0;
    bit         eFt = 1'b0;
    int         tickCount = 0;
    int         hc = 0;
    int         vc = 0;
    bit         curSw = 1'b1;
    bit         curGo = 1'b0;
`ifdef PROMPT_BLINK_EN
    int         mBc = 0;
`endif

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] packOut(input seq_state_t s, input bit ph, input int d);
        logic [1:0] d2;
        d2 = d[1:0];
        return {s == CHECK_SW, (s == READY) && ph, s == COUNTDOWN, d2, s == PLAY, (s == OVER) && ph};
    endfunction

    // Reference model of one posedge; pushes the expected overlay state on every tick.
    task automatic modelStep(input bit rstn, input bit sw, input bit btn, input bit go, input bit isTick);
        seq_state_t ns;
        bit start;
        if (!rstn) begin
            mState = CHECK_SW; mDigit = 3; mFc = 0; mPhase = 1'b1; mReq = 1'b0; eFt = 1'b0;
`ifdef PROMPT_BLINK_EN
            mBc = 0;
`endif
            sbQ.delete();
            return;
        end
        eFt = isTick;
        if (!isTick) begin
            if (btn) mReq = 1'b1;
            return;
        end
        start = mReq || btn;
        ns = mState;
        case (mState)
            CHECK_SW: if (!sw) ns = READY;
            READY: begin
                if (sw) ns = CHECK_SW;
                else if (start) begin ns = COUNTDOWN; mDigit = 3; mFc = 0; end
            end
            COUNTDOWN: begin
                if (mFc == COUNT_FRAMES - 1) begin
                    mFc = 0;
                    if (mDigit == 1) ns = PLAY;
                    else mDigit--;
                end else mFc++;
            end
            PLAY: if (go) begin ns = OVER; mFc = 0; end
            OVER: begin
                if (mFc == OVER_HOLD) begin
                    if (start) ns = CHECK_SW;
                end else mFc++;
            end
            default: ns = CHECK_SW;
        endcase
`ifdef PROMPT_BLINK_EN
        if (ns != mState && (ns == READY || ns == OVER)) begin
            mBc = 0; mPhase = 1'b1;
        end else if (mBc == BLINK_FRAMES - 1) begin
            mBc = 0; mPhase = !mPhase;
        end else mBc++;
`endif
        sbQ.push_back(packOut(ns, mPhase, mDigit));
        mState = ns;
        mReq = 1'b0;
        tickCount++;
    endtask

    task automatic applyStimulus(input bit rstn, input bit sw, input bit btn, input bit go);
        logic [6:0] exp;
        bit isTick;
        isTick = (hc == H_LAST) && (vc == V_LAST);
        rst = rstn; sw_any = sw; start_btn = btn; game_over = go;
        hCount = 10'(hc); vCount = 10'(vc);
        modelStep(rstn, sw, btn, go, isTick);
        @(posedge clk);
        @(negedge clk);
        checkOutput("frame_tick", {31'd0, frame_tick}, {31'd0, eFt});
        if (frame_tick === 1'b1) begin
            checkOutput("sb_avail", {31'd0, sbQ.size() > 0}, 32'd1);
            if (sbQ.size() > 0) begin
                exp = sbQ.pop_front();
                checkOutput("outputs", {25'd0, outVec}, {25'd0, exp});
            end
        end
        if (hc == H_LAST) begin
            hc = 0;
            vc = (vc == V_LAST) ? 0 : vc + 1;
        end else hc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, curSw, 1'b0, curGo);
    endtask

    task automatic frames(input int n);
        int target;
        target = tickCount + n;
        for (int i = 0; i < n * 60 && tickCount < target; i++) applyStimulus(1'b1, curSw, 1'b0, curGo);
    endtask

    task automatic pulseStart();
        applyStimulus(1'b1, curSw, 1'b1, curGo);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        @(negedge clk);

        // Reset with switches up, then the switches-off prompt and READY
        curSw = 1'b1;
        repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("rst_outs", {25'd0, outVec}, 32'b0001100);
        idle(10);
        checkOutput("pre_tick", {25'd0, outVec}, 32'b0001100);
        frames(1);
        checkOutput("sw_off_first", {31'd0, sw_off_en}, 32'd1);
        curSw = 1'b0;
        frames(1);
        checkOutput("ready_start_en", {31'd0, start_en}, 32'd1);

        // Countdown 3,2,1 then PLAY after 9 frames
        idle(20);
        pulseStart();
        frames(1);
        checkOutput("cd_entry", {29'd0, countdown_en, digit}, 32'b111);
        frames(3);
        checkOutput("cd_digit2", {30'd0, digit}, 32'd2);
        frames(3);
        checkOutput("cd_digit1", {30'd0, digit}, 32'd1);
        frames(2);
        checkOutput("game_en_8", {31'd0, game_en}, 32'd0);
        frames(1);
        checkOutput("game_en_9", {31'd0, game_en}, 32'd1);

        // Game over, early start ignored, late start accepted
        curGo = 1'b1;
        frames(1);
        checkOutput("over_entry", {31'd0, over_en}, 32'd1);
        curGo = 1'b0;
        frames(1);
        idle(10);
        pulseStart();
        frames(1);
        checkOutput("over_ignore", {31'd0, sw_off_en}, 32'd0);
`ifdef PROMPT_BLINK_EN
        checkOutput("over_blink_off", {31'd0, over_en}, 32'd0);
`else
        checkOutput("over_steady", {31'd0, over_en}, 32'd1);
`endif
        frames(2);
        curSw = 1'b1;
        idle(10);
        pulseStart();
        frames(1);
        checkOutput("over_exit", {31'd0, sw_off_en}, 32'd1);

        // Start on the tick with switches up: back to CHECK_SW, press discarded
        curSw = 1'b0;
        frames(1);
        idle(49);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("coinc_chk", {31'd0, sw_off_en}, 32'd1);
        frames(1);
        frames(1);
        checkOutput("start_discard", {31'd0, countdown_en}, 32'd0);

        // Six READY frames
        for (int i = 0; i < 6; i++) begin
            frames(1);
`ifndef PROMPT_BLINK_EN
            checkOutput("steady_start", {31'd0, start_en}, 32'd1);
`endif
        end

        // Reset in the middle of digit 2
        idle(10);
        pulseStart();
        frames(1);
        frames(3);
        checkOutput("cd_before_rst", {30'd0, digit}, 32'd2);
        idle(15);
        applyStimulus(1'b0, curSw, 1'b0, 1'b0);
        checkOutput("rst_mid", {25'd0, outVec}, 32'b0001100);
        curSw = 1'b1;
        frames(1);
        checkOutput("rst_recover", {31'd0, sw_off_en}, 32'd1);

        checkOutput("sb_drain", sbQ.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
